bucket_head_table: RTL and testbench

//  Parametrised per-bucket head-pointer table for the hash pipeline. It looks up {head_ptr, head_val}
//  for each request bucket with a fixed read latency. A lock table keeps modifying ops (insert/delete)
//  on one bucket strictly serialised. Write-back writes are forwarded into in-flight lookups.
//  A built-in INIT sweep clears the table.

---
 rtl/bucket_head_table_if.sv | 41 ++++
 rtl/bucket_head_table.sv | 152 +++++++++++++++
 tb/tb_bucket_head_table.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bucket_head_table_if.sv
// Request, response and write-back bundle of the bucket head-pointer table.
interface bucket_head_table_if #(
   parameter int BUCKET_W = 8,
   parameter int PTR_W    = 10,
   parameter int TAG_W    = 8
);
   logic [BUCKET_W-1:0] req_bucket;
   logic                req_modify;
   logic [TAG_W-1:0]    req_tag;
   logic                req_valid;
   logic                req_ready;

   logic [BUCKET_W-1:0] rsp_bucket;
   logic [TAG_W-1:0]    rsp_tag;
   logic [PTR_W-1:0]    rsp_head_ptr;
   logic                rsp_head_val;
   logic                rsp_valid;
   logic                rsp_ready;

   logic                wr_valid;
   logic                wr_we;
   logic [BUCKET_W-1:0] wr_bucket;
   logic [PTR_W-1:0]    wr_ptr;
   logic                wr_ptr_val;

   modport master (
      output req_bucket, req_modify, req_tag, req_valid,
      input  req_ready,
      input  rsp_bucket, rsp_tag, rsp_head_ptr, rsp_head_val, rsp_valid,
      output rsp_ready,
      output wr_valid, wr_we, wr_bucket, wr_ptr, wr_ptr_val
   );

   modport slave (
      input  req_bucket, req_modify, req_tag, req_valid,
      output req_ready,
      output rsp_bucket, rsp_tag, rsp_head_ptr, rsp_head_val, rsp_valid,
      input  rsp_ready,
      input  wr_valid, wr_we, wr_bucket, wr_ptr, wr_ptr_val
   );
endinterface

// File: rtl/bucket_head_table.sv
// Per-bucket head-pointer table: fixed-latency lookup, bucket lock CAM,
// write-back forwarding into in-flight lookups and a table clear sweep.
module bucket_head_table #(
   parameter int BUCKET_W  = 8,
   parameter int PTR_W     = 10,
   parameter int TAG_W     = 8,
   parameter int MAX_LOCKS = 4,
   parameter int REG_OUT   = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   bucket_head_table_if.slave bus,
   input  logic init,
   output logic init_busy,
   output logic err_unlock
);
   localparam int RD_LAT = 1 + REG_OUT;
   localparam int DEPTH  = 1 << BUCKET_W;
   localparam logic [BUCKET_W:0] LAST = (BUCKET_W+1)'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   state_t state, state_nx;
   logic [BUCKET_W:0] sw_cnt;

   logic [PTR_W:0] mem [DEPTH];

   logic [RD_LAT-1:0]   s_vld;
   logic [BUCKET_W-1:0] s_bkt  [RD_LAT];
   logic [TAG_W-1:0]    s_tag  [RD_LAT];
   logic [PTR_W:0]      s_head [RD_LAT];

   logic [MAX_LOCKS-1:0] lk_vld, lk_hit, lk_rel, lk_sel;
   logic [BUCKET_W-1:0]  lk_bkt [MAX_LOCKS];

   logic advance, hit, full, accept, acquire;
   logic fwd_we, pipe_empty, found;
   logic [PTR_W:0] wr_head;

   assign advance    = ~s_vld[RD_LAT-1] | bus.rsp_ready;
   assign pipe_empty = ~|s_vld;
   assign accept     = bus.req_valid & bus.req_ready;
   assign acquire    = accept & bus.req_modify;
   assign fwd_we     = bus.wr_valid & bus.wr_we & (state == IDLE);
   assign wr_head    = {bus.wr_ptr_val, bus.wr_ptr};

   always_comb begin
      lk_hit = '0;
      lk_rel = '0;
      lk_sel = '0;
      found  = 1'b0;
      for (int i = 0; i < MAX_LOCKS; i++) begin
         lk_hit[i] = lk_vld[i] && (lk_bkt[i] == bus.req_bucket);
         lk_rel[i] = lk_vld[i] && bus.wr_valid && (lk_bkt[i] == bus.wr_bucket);
         if (!lk_vld[i] && !found) begin
            lk_sel[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign hit  = |lk_hit;
   assign full = &lk_vld;

   // FSM: state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (init) state_nx = DRAIN;
         DRAIN:   if (pipe_empty) state_nx = CLEAR;
         CLEAR:   if (sw_cnt == LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      init_busy     = (state != IDLE);
      bus.req_ready = ~rst_i & (state == IDLE) & ~init & advance
                    & ~hit & ~(bus.req_modify & full);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)               sw_cnt <= '0;
      else if (state == CLEAR) sw_cnt <= sw_cnt + 1'b1;
      else                     sw_cnt <= '0;
   end

   always_ff @(posedge clk_i) begin
      if (state == CLEAR) mem[sw_cnt[BUCKET_W-1:0]] <= '0;
      else if (fwd_we)    mem[bus.wr_bucket] <= wr_head;
   end

   // Locks are flushed when the sweep starts so the cleared table is unlocked.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lk_vld     <= '0;
         err_unlock <= 1'b0;
      end else begin
         err_unlock <= bus.wr_valid & ~|lk_rel;
         if (state == DRAIN && state_nx == CLEAR)
            lk_vld <= '0;
         else
            lk_vld <= (lk_vld & ~lk_rel) | (acquire ? lk_sel : '0);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < MAX_LOCKS; i++)
         if (acquire && lk_sel[i]) lk_bkt[i] <= bus.req_bucket;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_vld <= '0;
      end else if (advance) begin
         s_vld[0] <= accept;
         for (int i = 1; i < RD_LAT; i++) s_vld[i] <= s_vld[i-1];
      end
   end

   // A same-edge write wins over the RAM read, so no read-during-write reliance.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         s_bkt[0]  <= bus.req_bucket;
         s_tag[0]  <= bus.req_tag;
         s_head[0] <= (fwd_we && bus.wr_bucket == bus.req_bucket)
                    ? wr_head : mem[bus.req_bucket];
         for (int i = 1; i < RD_LAT; i++) begin
            s_bkt[i]  <= s_bkt[i-1];
            s_tag[i]  <= s_tag[i-1];
            s_head[i] <= (fwd_we && s_bkt[i-1] == bus.wr_bucket)
                       ? wr_head : s_head[i-1];
         end
      end else begin
         for (int i = 0; i < RD_LAT; i++)
            if (fwd_we && s_bkt[i] == bus.wr_bucket) s_head[i] <= wr_head;
      end
   end

   assign bus.rsp_valid    = s_vld[RD_LAT-1];
   assign bus.rsp_bucket   = s_bkt[RD_LAT-1];
   assign bus.rsp_tag      = s_tag[RD_LAT-1];
   assign bus.rsp_head_ptr = s_head[RD_LAT-1][PTR_W-1:0];
   assign bus.rsp_head_val = s_head[RD_LAT-1][PTR_W];
endmodule

// File: tb/tb_bucket_head_table.sv
// Directed bench for bucket_head_table: sweep, latency, locks, forwarding,
// lock overflow, unlock error and reset in the middle of a clear.
module tb_bucket_head_table;
   localparam int BW = 4;
   localparam int PW = 10;
   localparam int TW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init = 1'b0;
   logic busy, err, busy2, err2;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cnt;

   always #5 clk = ~clk;

   bucket_head_table_if #(.BUCKET_W(BW), .PTR_W(PW), .TAG_W(TW)) bi ();
   bucket_head_table_if #(.BUCKET_W(BW), .PTR_W(PW), .TAG_W(TW)) bi2 ();

   assign bi2.req_bucket = bi.req_bucket;
   assign bi2.req_modify = bi.req_modify;
   assign bi2.req_tag    = bi.req_tag;
   assign bi2.req_valid  = bi.req_valid;
   assign bi2.rsp_ready  = bi.rsp_ready;
   assign bi2.wr_valid   = bi.wr_valid;
   assign bi2.wr_we      = bi.wr_we;
   assign bi2.wr_bucket  = bi.wr_bucket;
   assign bi2.wr_ptr     = bi.wr_ptr;
   assign bi2.wr_ptr_val = bi.wr_ptr_val;

   bucket_head_table #(
      .BUCKET_W(BW), .PTR_W(PW), .TAG_W(TW), .MAX_LOCKS(4), .REG_OUT(0)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .bus(bi.slave),
      .init(init), .init_busy(busy), .err_unlock(err)
   );

   bucket_head_table #(
      .BUCKET_W(BW), .PTR_W(PW), .TAG_W(TW), .MAX_LOCKS(4), .REG_OUT(1)
   ) u_dut2 (
      .clk_i(clk), .rst_i(rst), .bus(bi2.slave),
      .init(init), .init_busy(busy2), .err_unlock(err2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic m,
                          input logic [BW-1:0] b, input logic [TW-1:0] t);
      bi.req_valid  = v;
      bi.req_modify = m;
      bi.req_bucket = b;
      bi.req_tag    = t;
   endtask

   task automatic set_wr(input logic v, input logic we, input logic [BW-1:0] b,
                         input logic [PW-1:0] p, input logic pv);
      bi.wr_valid   = v;
      bi.wr_we      = we;
      bi.wr_bucket  = b;
      bi.wr_ptr     = p;
      bi.wr_ptr_val = pv;
   endtask

   task automatic rd_head(input string tag, input logic [BW-1:0] b,
                          input logic [PW:0] exp);
      set_req(1'b1, 1'b0, b, 8'hEE);
      tick;
      set_req(1'b0, 1'b0, '0, '0);
      chk({tag, " vld"}, 32'(bi.rsp_valid), 32'd1);
      chk({tag, " head"}, 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'(exp));
   endtask

   task automatic sweep(input string tag);
      init = 1'b1;
      tick;
      init = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         tick;
      end
      chk({tag, " busy cycles"}, 32'(cnt), 32'd17);
      chk({tag, " busy2 done"}, 32'(busy2), 32'd0);
   endtask

   initial begin
      set_req(1'b1, 1'b0, 4'd1, 8'h00);
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      bi.rsp_ready = 1'b1;
      tick;
      chk("rst ready", 32'(bi.req_ready), 32'd0);
      chk("rst rsp_valid", 32'(bi.rsp_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      set_req(1'b0, 1'b0, '0, '0);
      tick;
      rst = 1'b0;
      tick;

      // clear sweep and read back every bucket
      sweep("init");
      for (int b = 0; b < 16; b++) begin
         set_req(1'b1, 1'b0, 4'(b), 8'(b + 16));
         tick;
         chk("sweep vld", 32'(bi.rsp_valid), 32'd1);
         chk("sweep bkt", 32'(bi.rsp_bucket), 32'(b));
         chk("sweep head", 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'd0);
      end
      set_req(1'b0, 1'b0, '0, '0);
      tick;
      tick;

      // write then read, latency 1 and 2
      set_wr(1'b1, 1'b1, 4'd3, 10'h2A, 1'b1);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("wr nolock err", 32'(err), 32'd1);
      chk("wr nolock err2", 32'(err2), 32'd1);
      set_req(1'b1, 1'b0, 4'd3, 8'h55);
      #1;
      chk("rd3 ready", 32'(bi.req_ready), 32'd1);
      tick;
      set_req(1'b0, 1'b0, '0, '0);
      chk("lat1 vld", 32'(bi.rsp_valid), 32'd1);
      chk("lat1 head", 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'h42A);
      chk("lat1 tag", 32'(bi.rsp_tag), 32'h55);
      chk("lat2 early", 32'(bi2.rsp_valid), 32'd0);
      tick;
      chk("lat2 vld", 32'(bi2.rsp_valid), 32'd1);
      chk("lat2 head", 32'({bi2.rsp_head_val, bi2.rsp_head_ptr}), 32'h42A);
      chk("lat1 drained", 32'(bi.rsp_valid), 32'd0);
      tick;

      // lock blocks same-bucket reads only
      set_req(1'b1, 1'b1, 4'd5, 8'h01);
      #1;
      chk("mod5 ready", 32'(bi.req_ready), 32'd1);
      tick;
      set_req(1'b1, 1'b0, 4'd5, 8'h02);
      #1;
      chk("rd5 locked", 32'(bi.req_ready), 32'd0);
      set_req(1'b1, 1'b0, 4'd6, 8'h03);
      #1;
      chk("rd6 passes", 32'(bi.req_ready), 32'd1);
      tick;
      chk("rd6 tag", 32'(bi.rsp_tag), 32'h03);
      set_req(1'b1, 1'b0, 4'd5, 8'h04);
      set_wr(1'b1, 1'b1, 4'd5, 10'h011, 1'b1);
      #1;
      chk("rel same cycle", 32'(bi.req_ready), 32'd0);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("rel5 no err", 32'(err), 32'd0);
      chk("rd5 after rel", 32'(bi.req_ready), 32'd1);
      tick;
      set_req(1'b0, 1'b0, '0, '0);
      chk("rd5 head", 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'h411);
      chk("rd5 tag", 32'(bi.rsp_tag), 32'h04);
      tick;
      tick;

      // forwarding into in-flight lookups
      set_req(1'b1, 1'b0, 4'd7, 8'h70);
      set_wr(1'b1, 1'b1, 4'd7, 10'h03F, 1'b1);
      tick;
      set_req(1'b0, 1'b0, '0, '0);
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("fwd1 head", 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'h43F);
      tick;
      chk("fwd2 vld", 32'(bi2.rsp_valid), 32'd1);
      chk("fwd2 head", 32'({bi2.rsp_head_val, bi2.rsp_head_ptr}), 32'h43F);
      tick;
      bi.rsp_ready = 1'b0;
      set_req(1'b1, 1'b0, 4'd7, 8'h71);
      tick;
      set_req(1'b1, 1'b0, 4'd9, 8'h72);
      #1;
      chk("stall ready", 32'(bi.req_ready), 32'd0);
      chk("stall head0", 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'h43F);
      set_wr(1'b1, 1'b1, 4'd7, 10'h02C, 1'b0);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("stall fwd", 32'({bi.rsp_head_val, bi.rsp_head_ptr}), 32'h02C);
      chk("stall tag", 32'(bi.rsp_tag), 32'h71);
      tick;
      chk("stall hold vld", 32'(bi.rsp_valid), 32'd1);
      chk("stall hold", 32'({bi.rsp_head_val, bi.rsp_head_ptr, bi.rsp_tag}),
          32'h02C71);
      set_req(1'b0, 1'b0, '0, '0);
      bi.rsp_ready = 1'b1;
      tick;
      chk("stall drained", 32'(bi.rsp_valid), 32'd0);
      tick;
      tick;

      // lock table overflow and unlock error
      for (int b = 1; b <= 4; b++) begin
         set_req(1'b1, 1'b1, 4'(b), 8'(8'h80 + b));
         #1;
         chk("lock acq", 32'(bi.req_ready), 32'd1);
         tick;
      end
      set_req(1'b1, 1'b0, 4'd9, 8'h88);
      #1;
      chk("full read ok", 32'(bi.req_ready), 32'd1);
      set_req(1'b1, 1'b1, 4'd9, 8'h89);
      #1;
      chk("full blocks", 32'(bi.req_ready), 32'd0);
      set_wr(1'b1, 1'b0, 4'd8, '0, 1'b0);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("unlock err", 32'(err), 32'd1);
      chk("unlock no free", 32'(bi.req_ready), 32'd0);
      set_wr(1'b1, 1'b0, 4'd2, '0, 1'b0);
      #1;
      chk("rel2 same cyc", 32'(bi.req_ready), 32'd0);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("rel2 no err", 32'(err), 32'd0);
      chk("rel2 frees", 32'(bi.req_ready), 32'd1);
      tick;
      set_req(1'b0, 1'b0, '0, '0);
      set_wr(1'b1, 1'b0, 4'd1, '0, 1'b0);
      tick;
      set_wr(1'b1, 1'b0, 4'd3, '0, 1'b0);
      tick;
      set_wr(1'b1, 1'b0, 4'd4, '0, 1'b0);
      tick;
      set_wr(1'b1, 1'b0, 4'd9, '0, 1'b0);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      chk("rel9 no err", 32'(err), 32'd0);
      tick;

      // reset while clearing address 9
      set_wr(1'b1, 1'b1, 4'd2, 10'h099, 1'b1);
      tick;
      set_wr(1'b1, 1'b1, 4'd12, 10'h077, 1'b1);
      tick;
      set_wr(1'b0, 1'b0, '0, '0, 1'b0);
      tick;
      init = 1'b1;
      tick;
      init = 1'b0;
      tick;
      repeat (9) tick;
      chk("mid sweep busy", 32'(busy), 32'd1);
      rst = 1'b1;
      set_req(1'b1, 1'b0, 4'd1, 8'h00);
      #1;
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst vld", 32'(bi.rsp_valid), 32'd0);
      chk("mid rst err", 32'(err), 32'd0);
      chk("mid rst ready", 32'(bi.req_ready), 32'd0);
      set_req(1'b0, 1'b0, '0, '0);
      tick;
      rst = 1'b0;
      tick;
      rd_head("partial b2", 4'd2, 11'h000);
      rd_head("partial b12", 4'd12, 11'h477);
      tick;
      sweep("reinit");
      rd_head("reinit b12", 4'd12, 11'h000);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
